// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the lightweight-bridge PIO blocks: word address map
// and edge-capture type encodings.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_DIRECTION = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK   = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP   = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Clocks after reset release before edge terms may be trusted
  function automatic int warm_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/soc_system_sync_edge_det.sv
// Per-vector synchronizer chain with reset warm-up and registered edge detect.
// data_in is the last synchronizer stage; edge_vec pulses one clock per edge.
module soc_system_sync_edge_det
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] edge_vec
);

  localparam int WARM_MAX = warm_cycles(SYNC_STAGES);
  localparam int CNT_W    = $clog2(WARM_MAX + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] d_prev;
  logic [WIDTH-1:0] edge_raw;
  logic [CNT_W-1:0] warm_cnt;
  logic             warm_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign data_in   = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_cnt == CNT_W'(WARM_MAX));

  // Lines already high at reset release must not look like fresh edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + CNT_W'(1);
    end
  end

  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_rise
      assign edge_raw = data_in & ~d_prev;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign edge_raw = ~data_in & d_prev;
    end else begin : g_any
      assign edge_raw = data_in ^ d_prev;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_prev   <= '0;
      edge_vec <= '0;
    end else begin
      d_prev   <= data_in;
      edge_vec <= warm_done ? edge_raw : '0;
    end
  end

endmodule

// File: rtl/soc_system_status_in.sv
// Avalon-MM parallel input port: synchronized status lines, sticky edge
// capture with write-one-to-clear, and a masked level interrupt.
module soc_system_status_in
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_cap;

  soc_system_sync_edge_det #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .data_in  (data_in),
    .edge_vec (edge_vec)
  );

  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en && (address == ADDR_IRQMASK);
  assign wr_cap  = wr_en && (address == ADDR_EDGECAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_mask) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // New edges are OR'd in after the clear so a same-cycle edge is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else if (wr_cap) begin
      edge_cap <= (edge_cap & ~writedata[WIDTH-1:0]) | edge_vec;
    end else begin
      edge_cap <= edge_cap | edge_vec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irq_mask);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = data_in;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
      default:      readdata = '0;
    endcase
  end

endmodule
